// File: rtl/aud_recorder_if.sv
// SRAM write port driven by the audio recorder: one-cycle strobe with address and data.
interface aud_recorder_if;
   logic [19:0] address;
   logic [15:0] data;
   logic        valid;

   modport master (output address, data, valid);
   modport slave  (input  address, data, valid);
endinterface

// File: rtl/aud_recorder.sv
// I2S left-channel capture: deserialises 16-bit ADC samples and writes them to
// consecutive SRAM addresses, reporting recorded length and address-space exhaustion.
module aud_recorder (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_lrc,
   input  logic           i_data,
   input  logic           i_start,
   input  logic           i_pause,
   input  logic           i_stop,
   aud_recorder_if.master wr,
   output logic [19:0]    o_len,
   output logic           o_full
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_SKIP,
      S_SHIFT,
      S_WRITE,
      S_PAUSE
   } state_t;

   state_t      state, state_nxt;
   logic        lrc_q;
   logic [3:0]  cnt;
   logic [15:0] shreg;
   logic [19:0] wptr;
   logic [19:0] len_nxt;
   logic        clr_wptr, inc_wptr, ld_len, set_full, capture, clr_cnt;

   always_comb begin
      state_nxt = state;
      clr_wptr  = 1'b0;
      inc_wptr  = 1'b0;
      ld_len    = 1'b0;
      len_nxt   = wptr;
      set_full  = 1'b0;
      capture   = 1'b0;
      clr_cnt   = 1'b0;

      case (state)
         S_IDLE: begin
            if (i_start) begin
               state_nxt = S_WAIT;
               clr_wptr  = 1'b1;
            end
         end
         S_WAIT: begin
            if (lrc_q && !i_lrc) state_nxt = S_SKIP;
         end
         S_SKIP: begin
            state_nxt = S_SHIFT;
            clr_cnt   = 1'b1;
         end
         S_SHIFT: begin
            capture = 1'b1;
            if (cnt == 4'd15) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            inc_wptr = 1'b1;
            if (wptr == '1) begin
               state_nxt = S_IDLE;
               ld_len    = 1'b1;
               len_nxt   = '1;
               set_full  = 1'b1;
            end else begin
               state_nxt = S_WAIT;
            end
         end
         S_PAUSE: begin
            if (i_start) state_nxt = S_WAIT;
         end
         default: state_nxt = S_IDLE;
      endcase

      // Exhaustion already ends the recording with the full length; otherwise
      // stop beats pause, and a stop in WRITE still counts the write in progress.
      if (!set_full) begin
         if (i_stop && state != S_IDLE) begin
            state_nxt = S_IDLE;
            ld_len    = 1'b1;
            len_nxt   = (state == S_WRITE) ? wptr + 20'd1 : wptr;
         end else if (i_pause && (state == S_WAIT || state == S_SKIP ||
                                  state == S_SHIFT || state == S_WRITE)) begin
            state_nxt = S_PAUSE;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         lrc_q      <= 1'b1;
         cnt        <= '0;
         shreg      <= '0;
         wptr       <= '0;
         o_len      <= '0;
         o_full     <= 1'b0;
         wr.valid   <= 1'b0;
         wr.address <= '0;
         wr.data    <= '0;
      end else begin
         state <= state_nxt;
         lrc_q <= i_lrc;

         if (clr_cnt)      cnt <= '0;
         else if (capture) cnt <= cnt + 4'd1;

         if (capture) shreg <= {shreg[14:0], i_data};

         if (clr_wptr)      wptr <= '0;
         else if (inc_wptr) wptr <= wptr + 20'd1;

         if (ld_len) o_len <= len_nxt;

         if (set_full)      o_full <= 1'b1;
         else if (clr_wptr) o_full <= 1'b0;

         // The strobe and its payload are registered so that address/data
         // hold their last values between writes.
         wr.valid <= (state_nxt == S_WRITE);
         if (state_nxt == S_WRITE) begin
            wr.address <= wptr;
            wr.data    <= {shreg[14:0], i_data};
         end
      end
   end

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder: I2S frames with hand-chosen words, command
// pulses at fixed bit positions, and a strobe log compared against expected writes.
module tb_aud_recorder;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        lrc   = 1'b1;
   logic        sdata = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        stop  = 1'b0;
   logic [19:0] len;
   logic        full;

   aud_recorder_if bus ();

   aud_recorder dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_lrc   (lrc),
      .i_data  (sdata),
      .i_start (start),
      .i_pause (pause),
      .i_stop  (stop),
      .wr      (bus),
      .o_len   (len),
      .o_full  (full)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [19:0] wa[$];
   logic [15:0] wd[$];
   int          wc[$];
   int          falls[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.valid) begin
         wa.push_back(bus.address);
         wd.push_back(bus.data);
         wc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic chk_wr(input int i, input logic [19:0] a, input logic [15:0] d);
      if (i < wa.size()) begin
         chk($sformatf("wr%0d_addr", i), wa[i], a);
         chk($sformatf("wr%0d_data", i), wd[i], d);
      end else begin
         chk($sformatf("wr%0d_present", i), 0, 1);
      end
   endtask

   task automatic clr_log();
      wa.delete();
      wd.delete();
      wc.delete();
      falls.delete();
   endtask

   // n idle cycles with LRC high; command pulses land on the first cycle only.
   task automatic cycles(input int n, input bit s, input bit p, input bit t);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         lrc   = 1'b1;
         sdata = 1'b0;
         start = s && (i == 0);
         pause = p && (i == 0);
         stop  = t && (i == 0);
      end
   endtask

   // 64-cycle frame, left slot low for 32 cycles; drive k is sampled at edge N+k,
   // so bits 15..0 occupy k = 2..17. Other slots carry filler toggling.
   task automatic frame(input logic [15:0] w, input int ck, input bit s, input bit p,
                        input bit t);
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (k == 0) falls.push_back(cyc + 1);
         lrc   = (k >= 32);
         sdata = (k >= 2 && k <= 17) ? w[17 - k] : k[0];
         start = s && (k == ck);
         pause = p && (k == ck);
         stop  = t && (k == ck);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_addr", bus.address, 20'h0);
      chk("rst_data", bus.data, 16'h0);
      chk("rst_valid", bus.valid, 1'b0);
      chk("rst_len", len, 20'h0);
      chk("rst_full", full, 1'b0);
      rst_n = 1'b1;
      cycles(2, 0, 0, 0);

      // basic capture
      clr_log();
      cycles(2, 1, 0, 0);
      frame(16'hA5C3, -1, 0, 0, 0);
      frame(16'h0001, -1, 0, 0, 0);
      frame(16'h8000, -1, 0, 0, 0);
      cycles(2, 0, 0, 1);
      chk("basic_count", wa.size(), 3);
      chk_wr(0, 20'h0, 16'hA5C3);
      chk_wr(1, 20'h1, 16'h0001);
      chk_wr(2, 20'h2, 16'h8000);
      for (int i = 0; i < 3; i++)
         if (i < wc.size()) chk($sformatf("basic_lat%0d", i), wc[i] - falls[i], 17);
      chk("basic_len", len, 20'd3);
      chk("basic_full", full, 1'b0);

      // start while the left slot is already running
      clr_log();
      frame(16'h1111, 5, 1, 0, 0);
      frame(16'h2222, -1, 0, 0, 0);
      cycles(2, 0, 0, 1);
      chk("mid_count", wa.size(), 1);
      chk_wr(0, 20'h0, 16'h2222);
      if (wc.size() > 0) chk("mid_lat", wc[0] - falls[1], 17);
      chk("mid_len", len, 20'd1);

      // pause at bit 8 of the second sample, then resume
      clr_log();
      cycles(2, 1, 0, 0);
      frame(16'h1234, -1, 0, 0, 0);
      frame(16'h5678, 9, 0, 1, 0);
      cycles(2, 1, 0, 0);
      frame(16'h9ABC, -1, 0, 0, 0);
      cycles(2, 0, 0, 1);
      chk("pause_count", wa.size(), 2);
      chk_wr(0, 20'h0, 16'h1234);
      chk_wr(1, 20'h1, 16'h9ABC);
      chk("pause_len", len, 20'd2);

      // pause and stop together go to IDLE
      clr_log();
      cycles(2, 1, 0, 0);
      frame(16'h4321, 9, 0, 1, 1);
      frame(16'h1111, -1, 0, 0, 0);
      chk("ps_count", wa.size(), 0);
      chk("ps_len", len, 20'd0);

      // stop in the WRITE cycle keeps that write
      clr_log();
      cycles(2, 1, 0, 0);
      frame(16'hDEAD, -1, 0, 0, 0);
      frame(16'hBEEF, 18, 0, 0, 1);
      frame(16'h0F0F, -1, 0, 0, 0);
      chk("sw_count", wa.size(), 2);
      chk_wr(0, 20'h0, 16'hDEAD);
      chk_wr(1, 20'h1, 16'hBEEF);
      chk("sw_len", len, 20'd2);

      // address space exhaustion
      clr_log();
      cycles(2, 1, 0, 0);
      @(negedge clk);
      force dut.wptr = 20'hFFFFE;
      @(negedge clk);
      release dut.wptr;
      frame(16'h1357, -1, 0, 0, 0);
      frame(16'h2468, -1, 0, 0, 0);
      frame(16'h3333, -1, 0, 0, 0);
      chk("full_count", wa.size(), 2);
      chk_wr(0, 20'hFFFFE, 16'h1357);
      chk_wr(1, 20'hFFFFF, 16'h2468);
      chk("full_flag", full, 1'b1);
      chk("full_len", len, 20'hFFFFF);
      cycles(2, 1, 0, 0);
      chk("full_clr", full, 1'b0);

      // asynchronous reset in the middle of SHIFT
      clr_log();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         lrc   = 1'b0;
         sdata = k[0];
         start = 1'b0;
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_addr", bus.address, 20'h0);
      chk("arst_data", bus.data, 16'h0);
      chk("arst_valid", bus.valid, 1'b0);
      chk("arst_len", len, 20'h0);
      chk("arst_full", full, 1'b0);
      @(negedge clk);
      lrc   = 1'b1;
      rst_n = 1'b1;
      cycles(2, 1, 0, 0);
      frame(16'h7777, -1, 0, 0, 0);
      cycles(2, 0, 0, 1);
      chk("arst_count", wa.size(), 1);
      chk_wr(0, 20'h0, 16'h7777);
      chk("arst_len1", len, 20'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
